// File: rtl/vga_overlay_pkg.sv
// vga_overlay_pkg: shared constants and pipeline bundle for the
// VGA text/picture overlay.
package vga_overlay_pkg;

  localparam int FONT_W  = 8;
  localparam int FONT_H  = 16;
  localparam int FONT_AW = 11;

  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [2:0] RGB_BLACK  = 3'b000;
  localparam logic [2:0] RGB_WHITE  = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       in_pic;
    logic       in_text;
    logic [2:0] col;
    logic       cur_hit;
  } pix_side_t;

  function automatic logic [2:0] rgb_rev(input logic [2:0] c);
    return {c[0], c[1], c[2]};
  endfunction

endpackage

// File: rtl/text_char_buf.sv
// text_char_buf: writable text cell codes plus cursor position,
// with a combinational cell-index read port.
module text_char_buf
  import vga_overlay_pkg::*;
#(
  parameter int NUM_CHARS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [5:0] i_wr_idx,
  input  logic [6:0] i_wr_code,
  input  logic       i_cur_wr,
  input  logic [5:0] i_cur_idx,
  input  logic [5:0] i_rd_idx,
  output logic [6:0] o_rd_code,
  output logic [5:0] o_cur_pos
);

  logic [6:0] r_cells [NUM_CHARS];
  logic [5:0] r_cur_pos;
  logic       w_wr_ok;
  logic       w_cur_ok;

  assign w_wr_ok  = i_wr_en && ({26'd0, i_wr_idx} < NUM_CHARS);
  assign w_cur_ok = i_cur_wr && ({26'd0, i_cur_idx} < NUM_CHARS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_cells[i] <= CHAR_SPACE;
      end
      r_cur_pos <= '0;
    end else begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (w_wr_ok && i_wr_idx == 6'(i)) begin
          r_cells[i] <= i_wr_code;
        end
      end
      if (w_cur_ok) begin
        r_cur_pos <= i_cur_idx;
      end
    end
  end

  // Indices past the last cell read back as a space.
  always_comb begin
    o_rd_code = CHAR_SPACE;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (i_rd_idx == 6'(i)) begin
        o_rd_code = r_cells[i];
      end
    end
  end

  assign o_cur_pos = r_cur_pos;

endmodule

// File: rtl/vga_text_overlay.sv
// vga_text_overlay: 3-clock pixel pipeline compositing a picture ROM
// window, a font-ROM text line and a frame-counted blinking cursor.
module vga_text_overlay
  import vga_overlay_pkg::*;
#(
  parameter int         PIC_X        = 240,
  parameter int         PIC_Y        = 180,
  parameter int         PIC_W        = 160,
  parameter int         PIC_H        = 120,
  parameter int         TEXT_X       = 100,
  parameter int         TEXT_Y       = 400,
  parameter int         NUM_CHARS    = 16,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] TEXT_RGB     = RGB_WHITE,
  parameter logic [2:0] BG_RGB       = RGB_BLACK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [5:0]         wr_idx,
  input  logic [6:0]         wr_code,
  input  logic               cur_wr,
  input  logic [5:0]         cur_idx,
  input  logic               cursor_en,
  output logic [14:0]        pic_adr,
  input  logic [2:0]         pic_rgb,
  output logic [FONT_AW-1:0] font_adr,
  input  logic [7:0]         font_data,
  output logic [2:0]         rgbo
);

  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic        w_in_pic;
  logic        w_in_text;
  logic [14:0] w_pic_off;
  logic [8:0]  w_tdx;
  logic [3:0]  w_row;
  logic [5:0]  w_cell;
  logic [6:0]  w_code;
  logic [5:0]  w_cur_pos;
  logic        w_cur_hit;
  logic        w_font_bit;
  logic [2:0]  w_rgb;
  pix_side_t   w_side;
  pix_side_t   r1_side;
  pix_side_t   r2_side;
  logic [15:0] r_blink_cnt;
  logic        r_blink_on;

  assign w_x32 = {22'd0, x};
  assign w_y32 = {22'd0, y};

  assign w_in_pic = (w_x32 >= PIC_X) &&
                    (w_x32 < PIC_X + PIC_W) &&
                    (w_y32 >= PIC_Y) &&
                    (w_y32 < PIC_Y + PIC_H);

  // Column-major picture address.
  assign w_pic_off =
    15'((w_x32 - PIC_X) * PIC_H + (w_y32 - PIC_Y));

  assign w_in_text = (w_x32 >= TEXT_X) &&
                     (w_x32 < TEXT_X + FONT_W * NUM_CHARS) &&
                     (w_y32 >= TEXT_Y) &&
                     (w_y32 < TEXT_Y + FONT_H);

  assign w_tdx  = 9'(w_x32 - TEXT_X);
  assign w_cell = w_tdx[8:3];
  assign w_row  = 4'(w_y32 - TEXT_Y);

  text_char_buf #(
    .NUM_CHARS(NUM_CHARS)
  ) u_buf (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wr_en  (wr_en),
    .i_wr_idx (wr_idx),
    .i_wr_code(wr_code),
    .i_cur_wr (cur_wr),
    .i_cur_idx(cur_idx),
    .i_rd_idx (w_cell),
    .o_rd_code(w_code),
    .o_cur_pos(w_cur_pos)
  );

  assign w_cur_hit = cursor_en && r_blink_on &&
                     pix_valid && w_in_text &&
                     (w_cell == w_cur_pos);

  always_comb begin
    w_side         = '0;
    w_side.valid   = pix_valid;
    w_side.in_pic  = w_in_pic;
    w_side.in_text = w_in_text;
    w_side.col     = w_tdx[2:0];
    w_side.cur_hit = w_cur_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (r_blink_cnt == 16'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  // MSB of the font row is the leftmost pixel.
  assign w_font_bit = font_data[3'd7 - r2_side.col];

  always_comb begin
    w_rgb = BG_RGB;
    if (!r2_side.valid) begin
      w_rgb = RGB_BLACK;
    end else if (r2_side.in_text && w_font_bit) begin
      w_rgb = TEXT_RGB;
    end else if (r2_side.in_pic) begin
      w_rgb = rgb_rev(pic_rgb);
    end
    if (r2_side.cur_hit) begin
      w_rgb = w_rgb ^ 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pic_adr  <= '0;
      font_adr <= '0;
      r1_side  <= '0;
      r2_side  <= '0;
      rgbo     <= '0;
    end else begin
      pic_adr  <= w_in_pic ? w_pic_off : '0;
      font_adr <= w_in_text ? {w_code, w_row} : '0;
      r1_side  <= w_side;
      r2_side  <= r1_side;
      rgbo     <= w_rgb;
    end
  end

endmodule

// File: tb/tb_vga_text_overlay.sv
// tb_vga_text_overlay: directed pixels with a latency-tagged scoreboard
// for two instances (default layout and text inside the picture).
module tb_vga_text_overlay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_idx = '0;
  logic [6:0]  wr_code = '0;
  logic        cur_wr = 1'b0;
  logic [5:0]  cur_idx = '0;
  logic        cursor_en = 1'b0;

  logic [14:0] pic_adr_a, pic_adr_b;
  logic [10:0] font_adr_a, font_adr_b;
  logic [2:0]  rgbo_a, rgbo_b;
  logic [2:0]  pic_rgb_a = '0;
  logic [2:0]  pic_rgb_b = '0;
  logic [7:0]  font_data_a = '0;
  logic [7:0]  font_data_b = '0;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         due;
    string      nm;
    bit         inst;
    logic [2:0] rgb;
  } rgb_exp_t;

  typedef struct {
    int          due;
    string       nm;
    bit          inst;
    logic [14:0] pa;
    logic [10:0] fa;
  } adr_exp_t;

  rgb_exp_t q_rgb[$];
  adr_exp_t q_adr[$];

  vga_text_overlay u_a (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
    .cur_wr(cur_wr), .cur_idx(cur_idx), .cursor_en(cursor_en),
    .pic_adr(pic_adr_a), .pic_rgb(pic_rgb_a),
    .font_adr(font_adr_a), .font_data(font_data_a),
    .rgbo(rgbo_a)
  );

  vga_text_overlay #(.TEXT_X(248), .TEXT_Y(184)) u_b (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
    .cur_wr(cur_wr), .cur_idx(cur_idx), .cursor_en(cursor_en),
    .pic_adr(pic_adr_b), .pic_rgb(pic_rgb_b),
    .font_adr(font_adr_b), .font_data(font_data_b),
    .rgbo(rgbo_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Picture ROM content: low address bits XOR 3'b011.
  function automatic logic [2:0] pic_rom(input logic [2:0] lo);
    return lo ^ 3'b011;
  endfunction

  // Font ROM: every row of a glyph is the same byte.
  function automatic logic [7:0] font_rom(input logic [6:0] code);
    case (code)
      7'h20:   return 8'h00;
      7'h31:   return 8'h80;
      7'h55:   return 8'hAA;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) begin
    pic_rgb_a   <= pic_rom(pic_adr_a[2:0]);
    pic_rgb_b   <= pic_rom(pic_adr_b[2:0]);
    font_data_a <= font_rom(font_adr_a[10:4]);
    font_data_b <= font_rom(font_adr_b[10:4]);
  end

  always @(negedge clk) begin : monitor
    rgb_exp_t   er_e;
    adr_exp_t   ea_e;
    logic [2:0] act;
    logic [14:0] apa;
    logic [10:0] afa;
    while (q_adr.size() > 0 && q_adr[0].due <= cyc) begin
      ea_e = q_adr.pop_front();
      apa = ea_e.inst ? pic_adr_b : pic_adr_a;
      afa = ea_e.inst ? font_adr_b : font_adr_a;
      n_total++;
      if (ea_e.due == cyc && apa === ea_e.pa && afa === ea_e.fa)
        n_pass++;
      else
        $display("FAIL %s: pic_adr=%0d font_adr=%h expected %0d %h",
                 ea_e.nm, apa, afa, ea_e.pa, ea_e.fa);
    end
    while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
      er_e = q_rgb.pop_front();
      act = er_e.inst ? rgbo_b : rgbo_a;
      n_total++;
      if (er_e.due == cyc && act === er_e.rgb)
        n_pass++;
      else
        $display("FAIL %s: rgbo=%b expected %b",
                 er_e.nm, act, er_e.rgb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int px, input int py, input bit v);
    x = 10'(px);
    y = 10'(py);
    pix_valid = v;
  endtask

  task automatic er(input string nm, input bit inst,
                    input logic [2:0] v);
    q_rgb.push_back('{cyc + 3, nm, inst, v});
  endtask

  task automatic ea(input string nm, input bit inst,
                    input logic [14:0] pa, input logic [10:0] fa);
    q_adr.push_back('{cyc + 1, nm, inst, pa, fa});
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      drive(0, 0, 0);
      tick();
    end
    frame_start = 1'b0;
  endtask

  task automatic px_chk(input string nm, input int px, input int py,
                        input logic [2:0] v);
    drive(px, py, 1);
    er(nm, 0, v);
    tick();
  endtask

  initial begin
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(241, 182, 1);
      ea("rst_adr", 0, 15'd0, 11'h000);
      er("rst_rgb", 0, 3'b000);
      tick();
    end
    rst = 1'b0;

    drive(241, 182, 0);
    ea("blank_adr_pic", 0, 15'd122, 11'h000);
    er("blank_pic", 0, 3'b000);
    tick();
    drive(100, 403, 0);
    ea("blank_adr_txt", 0, 15'd0, 11'h203);
    er("blank_txt", 0, 3'b000);
    tick();
    drive(300, 200, 0);
    er("blank_mid", 0, 3'b000);
    tick();

    wr_en = 1'b1; wr_idx = 6'd16; wr_code = 7'h41;
    drive(0, 0, 0);
    tick();
    wr_idx = 6'd63;
    tick();
    wr_en = 1'b0;
    drive(100, 402, 1); ea("oor_c0", 0, 15'd0, 11'h202);
    er("oor_c0_rgb", 0, 3'b000); tick();
    drive(140, 402, 1); ea("oor_c5", 0, 15'd0, 11'h202); tick();
    drive(220, 402, 1); ea("oor_c15", 0, 15'd0, 11'h202); tick();

    drive(227, 415, 1); ea("txt_corner", 0, 15'd0, 11'h20F); tick();
    drive(228, 415, 1); ea("txt_right", 0, 15'd0, 11'h000); tick();
    drive(227, 416, 1); ea("txt_below", 0, 15'd0, 11'h000); tick();
    drive(99, 403, 1);  ea("txt_left", 0, 15'd0, 11'h000); tick();

    drive(241, 182, 1); ea("pic_adr", 0, 15'd122, 11'h000);
    er("pic_rgb", 0, 3'b100); tick();
    drive(240, 180, 1); ea("pic_tl", 0, 15'd0, 11'h000);
    er("pic_tl_rgb", 0, 3'b110); tick();
    drive(399, 299, 1); ea("pic_br", 0, 15'd19199, 11'h000);
    er("pic_br_rgb", 0, 3'b001); tick();
    drive(400, 299, 1); ea("pic_right", 0, 15'd0, 11'h000);
    er("pic_right_rgb", 0, 3'b000); tick();
    drive(240, 300, 1); ea("pic_below", 0, 15'd0, 11'h000); tick();
    px_chk("pic_left_rgb", 239, 180, 3'b000);

    wr_en = 1'b1; wr_idx = 6'd0; wr_code = 7'h31;
    drive(100, 403, 1);
    ea("wr_same_cyc", 0, 15'd0, 11'h203);
    er("wr_same_rgb", 0, 3'b000);
    tick();
    wr_en = 1'b0;
    drive(100, 403, 1); ea("wr_new", 0, 15'd0, 11'h313);
    er("txt_on", 0, 3'b111); tick();
    drive(101, 403, 1); ea("wr_new_c1", 0, 15'd0, 11'h313);
    er("txt_off", 0, 3'b000); tick();

    wr_en = 1'b1; wr_idx = 6'd1; wr_code = 7'h55;
    cur_wr = 1'b1; cur_idx = 6'd2; cursor_en = 1'b1;
    drive(0, 0, 0);
    tick();
    wr_en = 1'b0; cur_wr = 1'b0;
    px_chk("cur_on", 116, 405, 3'b111);
    px_chk("cur_other", 109, 405, 3'b000);
    px_chk("cur_col3", 119, 405, 3'b111);
    cur_wr = 1'b1; cur_idx = 6'd16;
    drive(0, 0, 0);
    tick();
    cur_wr = 1'b0;
    px_chk("cur_oor", 116, 405, 3'b111);

    pulses(29);
    px_chk("blink_29", 116, 405, 3'b111);
    pulses(1);
    px_chk("blink_off", 116, 405, 3'b000);
    pulses(29);
    px_chk("blink_off_59", 116, 405, 3'b000);
    pulses(1);
    px_chk("blink_back", 116, 405, 3'b111);

    cur_wr = 1'b1; cur_idx = 6'd0;
    drive(0, 0, 0);
    tick();
    cur_wr = 1'b0;
    px_chk("cur_xor_text", 100, 403, 3'b000);
    cursor_en = 1'b0;

    drive(248, 190, 1); ea("ovl_adr0", 1, 15'd970, 11'h316);
    er("ovl_bit1", 1, 3'b111); tick();
    drive(249, 190, 1); er("ovl_bit0", 1, 3'b100); tick();
    drive(256, 190, 1); ea("ovl_adr1", 1, 15'd1930, 11'h556);
    er("ovl_c1_bit1", 1, 3'b111); tick();
    drive(257, 195, 1); er("ovl_c1_bit0", 1, 3'b001); tick();
    drive(258, 195, 1); er("ovl_c1_bit1b", 1, 3'b111); tick();

    drive(0, 0, 0);
    repeat (6) tick();
    while (q_adr.size() > 0) begin
      n_total++;
      $display("FAIL %s: address never checked", q_adr[0].nm);
      void'(q_adr.pop_front());
    end
    while (q_rgb.size() > 0) begin
      n_total++;
      $display("FAIL %s: colour never checked", q_rgb[0].nm);
      void'(q_rgb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
